// File: rtl/lvds_pll_lock_sequencer.sv
// LVDS receiver PLL power-up/recovery sequencer, clocked from the free-running reference clock.
// Define LVDS_PLL_SEQ_STATS_EN to implement the lock-loss and timeout statistics counters.
module lvds_pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 125000,
    parameter int unsigned DPA_CYCLES     = 32
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_restart,
    input  logic        i_pll_locked,
    output logic        o_pll_rst,
    output logic        o_dpa_reset,
    output logic        o_rx_reset_n,
    output logic        o_ready,
    output logic [2:0]  o_state,
    output logic [15:0] o_lock_loss_cnt,
    output logic [15:0] o_timeout_cnt
);
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PLL_RST     = 3'd1,
        S_WAIT_LOCK   = 3'd2,
        S_LOCK_STABLE = 3'd3,
        S_DPA_RST     = 3'd4,
        S_READY       = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        sync1_q, sync2_q, lock_s;
    logic        enter, lock_loss_ev, timeout_ev;
    logic        pll_rst_q, dpa_reset_q, rx_reset_n_q, ready_q;
    logic [2:0]  state_out_q;

    assign lock_s = sync2_q;

    // Flushed while the PLL is held in reset so a lock seen before the reset
    // can never shortcut the post-reset settling of the synchronizer.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || state_q == S_IDLE || state_q == S_PLL_RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_pll_locked;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
        enter        = 1'b0;
        lock_loss_ev = 1'b0;
        timeout_ev   = 1'b0;
        if (!i_enable) begin
            state_d = S_IDLE;
        end else if (i_restart && state_q != S_IDLE) begin
            state_d = S_PLL_RST;
            enter   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PLL_RST;
                    enter   = 1'b1;
                end
                S_PLL_RST: begin
                    if (cnt_q == 32'd0) begin
                        state_d = S_WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_LOCK_STABLE;
                        enter   = 1'b1;
                    end else if (cnt_q == 32'd0) begin
                        state_d    = S_PLL_RST;
                        enter      = 1'b1;
                        timeout_ev = 1'b1;
                    end
                end
                S_LOCK_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        enter   = 1'b1;
                    end else if (cnt_q == 32'd0) begin
                        state_d = S_DPA_RST;
                        enter   = 1'b1;
                    end
                end
                S_DPA_RST: begin
                    if (!lock_s) begin
                        state_d = S_PLL_RST;
                        enter   = 1'b1;
                    end else if (cnt_q == 32'd0) begin
                        state_d = S_READY;
                        enter   = 1'b1;
                    end
                end
                S_READY: begin
                    if (!lock_s) begin
                        state_d      = S_PLL_RST;
                        enter        = 1'b1;
                        lock_loss_ev = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // The shared counter counts down to zero; the phase ends on the zero cycle.
        if (enter) begin
            case (state_d)
                S_PLL_RST:     cnt_d = RESET_CYCLES - 32'd1;
                S_WAIT_LOCK:   cnt_d = TIMEOUT_CYCLES;
                S_LOCK_STABLE: cnt_d = STABLE_CYCLES - 32'd1;
                S_DPA_RST:     cnt_d = DPA_CYCLES - 32'd1;
                default:       cnt_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_out_q  <= 3'd0;
            pll_rst_q    <= 1'b1;
            dpa_reset_q  <= 1'b0;
            rx_reset_n_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_out_q  <= state_q;
            pll_rst_q    <= (state_q == S_IDLE) || (state_q == S_PLL_RST);
            dpa_reset_q  <= (state_q == S_DPA_RST);
            rx_reset_n_q <= (state_q == S_READY);
            ready_q      <= (state_q == S_READY);
        end
    end

    assign o_state      = state_out_q;
    assign o_pll_rst    = pll_rst_q;
    assign o_dpa_reset  = dpa_reset_q;
    assign o_rx_reset_n = rx_reset_n_q;
    assign o_ready      = ready_q;

`ifdef LVDS_PLL_SEQ_STATS_EN
    logic [15:0] lock_loss_cnt_q, timeout_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lock_loss_cnt_q <= 16'h0000;
            timeout_cnt_q   <= 16'h0000;
        end else begin
            if (lock_loss_ev && lock_loss_cnt_q != 16'hFFFF)
                lock_loss_cnt_q <= lock_loss_cnt_q + 16'h0001;
            if (timeout_ev && timeout_cnt_q != 16'hFFFF)
                timeout_cnt_q <= timeout_cnt_q + 16'h0001;
        end
    end

    assign o_lock_loss_cnt = lock_loss_cnt_q;
    assign o_timeout_cnt   = timeout_cnt_q;
`else
    logic unused_stat_ev;
    assign unused_stat_ev  = lock_loss_ev ^ timeout_ev;
    assign o_lock_loss_cnt = 16'h0000;
    assign o_timeout_cnt   = 16'h0000;
`endif

endmodule

// File: doc/lvds_pll_lock_sequencer.md
# lvds_pll_lock_sequencer

Sequences power-up and recovery of the LVDS receiver PLL in the MuPix receiver block.
- Holds the PLL in reset, waits for a stable lock, pulses the receiver DPA reset, then declares the link clocking ready.
- Restarts the whole sequence on loss of lock, lock timeout or software request.
- Runs on the free-running 125 MHz reference clock, never on a PLL output clock.

## Interface
Parameters:
- RESET_CYCLES, 16 — cycles `o_pll_rst` is held high per attempt (≥1).
- STABLE_CYCLES, 1024 — consecutive synchronized-locked cycles required before lock is accepted (≥1).
- TIMEOUT_CYCLES, 125000 — maximum cycles in WAIT_LOCK before retry (1 ms at 125 MHz).
- DPA_CYCLES, 32 — width of the `o_dpa_reset` pulse (≥1).

Ports:
- `i_clk` in 1 — 125 MHz reference clock; the block's one clock.
- `i_reset_n` in 1 — reset, synchronous to `i_clk`, active low.
- `i_enable` in 1 — when low, the block is forced to IDLE with the PLL held in reset.
- `i_restart` in 1 — single-cycle request to rerun the sequence from PLL_RST.
- `i_pll_locked` in 1 — PLL locked flag, asynchronous to `i_clk`.
- `o_pll_rst` out 1 — PLL reset, active high.
- `o_dpa_reset` out 1 — receiver DPA/alignment reset, active high.
- `o_rx_reset_n` out 1 — receiver datapath reset, active low.
- `o_ready` out 1 — clocking stable, receivers released.
- `o_state` out 3 — current state encoding.
- `o_lock_loss_cnt` out 16 — count of lock losses from READY; saturates at 0xFFFF.
- `o_timeout_cnt` out 16 — count of WAIT_LOCK timeouts; saturates at 0xFFFF.

## Operation
- `i_pll_locked` passes through a 2-flop synchronizer; `lock_s` denotes its output. All decisions use `lock_s`.
- One shared down-counter is loaded on every state entry.
- States and encodings:
  - IDLE=0: `o_pll_rst`=1. Go to PLL_RST when `i_enable`=1.
  - PLL_RST=1: `o_pll_rst`=1 for RESET_CYCLES, then go to WAIT_LOCK.
  - WAIT_LOCK=2: `lock_s`=1 → LOCK_STABLE. After TIMEOUT_CYCLES without lock, increment `o_timeout_cnt` and go to PLL_RST.
  - LOCK_STABLE=3: needs STABLE_CYCLES consecutive cycles of `lock_s`=1, then → DPA_RST. Any `lock_s`=0 returns to WAIT_LOCK with a fresh timeout; this is not counted.
  - DPA_RST=4: `o_dpa_reset`=1 for DPA_CYCLES, then → READY. If `lock_s`=0, go to PLL_RST.
  - READY=5: `o_ready`=1 and `o_rx_reset_n`=1. On `lock_s`=0, increment `o_lock_loss_cnt` and go to PLL_RST.
- `o_rx_reset_n`=0 in every state except READY.
- Event priority, highest first:
  1. `i_reset_n`=0
  2. `i_enable`=0 → IDLE
  3. `i_restart`=1 → PLL_RST from any non-IDLE state; counters unchanged
  4. lock loss or timeout
  5. counter expiry
- `i_restart` while in IDLE is ignored.
- Counters saturate and never wrap. They clear only on `i_reset_n`.

## Timing
- All outputs are registered and reflect the registered state.
- Every output changes one cycle after the state register updates.
- Reset values after `i_reset_n`=0 at a clock edge:
  - `o_state`=0, `o_pll_rst`=1, `o_dpa_reset`=0, `o_rx_reset_n`=0, `o_ready`=0
  - both counters 0; synchronizer flops 0
- Reset mid-sequence aborts immediately to IDLE with the values above.
- Lock detection latency is 2 cycles through the synchronizer plus 1 state cycle. Lock-loss reaction from READY is therefore ≤3 cycles to `o_ready`=0 and `o_pll_rst`=1.
- Phase durations: exactly RESET_CYCLES, STABLE_CYCLES and DPA_CYCLES cycles of the respective output or condition, with no off-by-one.
- Minimum time from `i_enable` rising to `o_ready`:
  - 1 (IDLE exit) + RESET_CYCLES + 2 (sync) + 1 + STABLE_CYCLES + DPA_CYCLES
  - = 1076 cycles at the default parameters, with lock present immediately.
- Counter increment and the resulting state transition occur on the same edge.

## Configuration
- Macro `LVDS_PLL_SEQ_STATS_EN`.
- Defined: `o_lock_loss_cnt` and `o_timeout_cnt` are implemented as described.
- Undefined:
  - both counters are removed and the outputs are tied to 16'h0000;
  - state sequencing is identical, including the timeout retry.

## Test plan
- Reset release with `i_enable`=1 and `i_pll_locked` tied 1 → `o_ready` rises 1076 cycles after the first enabled edge; `o_dpa_reset` is high for exactly 32 cycles; `o_pll_rst` is high for exactly 16 cycles.
- `i_pll_locked`=0 permanently, TIMEOUT_CYCLES=100 → PLL_RST/WAIT_LOCK repeat every 117 cycles; `o_timeout_cnt` reaches 3 after three windows; `o_ready` stays 0.
- In READY, drop `i_pll_locked` for 1 cycle → within 3 cycles `o_ready`=0, `o_rx_reset_n`=0, `o_pll_rst`=1, `o_lock_loss_cnt`=1; the sequence then re-completes.
- In LOCK_STABLE, glitch `i_pll_locked` low at cycle 500 → returns to WAIT_LOCK, the full 1024-cycle stable window restarts, counters unchanged.
- `i_restart` pulsed in READY, and `i_enable` dropped in DPA_RST → first case goes to PLL_RST with counters unchanged; second goes to IDLE with `o_pll_rst`=1. A restart pulse in IDLE has no effect.
- Force `o_lock_loss_cnt` near saturation (0xFFFE, then two further losses) → holds at 0xFFFF. Build without `LVDS_PLL_SEQ_STATS_EN` → both counters read 0 and state traces match the enabled build.
